// File: rtl/oled_spi_sequencer_if.sv
// Groups the control, init-ROM, byte-stream and OLED pin signals of oled_spi_sequencer.
// The master modport is the sequencer side; slave is its environment (user logic, ROM, panel).
interface oled_spi_sequencer_if #(
    parameter int ROM_AW = 5
);
    logic              start;
    logic [ROM_AW-1:0] rom_addr;
    logic [8:0]        rom_data;
    logic              tx_valid;
    logic              tx_ready;
    logic [7:0]        tx_data;
    logic              tx_dc;
    logic              busy;
    logic              init_done;
    logic              RESb;
    logic              DCb;
    logic              OLED_CSb;
    logic              OLED_SCK;
    logic              OLED_SDOUT;

    modport master (
        input  start, rom_data, tx_valid, tx_data, tx_dc,
        output rom_addr, tx_ready, busy, init_done,
        output RESb, DCb, OLED_CSb, OLED_SCK, OLED_SDOUT
    );

    modport slave (
        output start, rom_data, tx_valid, tx_data, tx_dc,
        input  rom_addr, tx_ready, busy, init_done,
        input  RESb, DCb, OLED_CSb, OLED_SCK, OLED_SDOUT
    );
endinterface

// File: rtl/oled_spi_sequencer.sv
// OLED SPI master: power-up reset sequencing, init list streaming from a registered ROM,
// then a valid/ready byte port. SPI mode 3, MSB first; every output is a register.
module oled_spi_sequencer #(
    parameter int CLK_DIV         = 4,
    parameter int RES_LOW_CYCLES  = 1000,
    parameter int RES_WAIT_CYCLES = 1000,
    parameter int INIT_LEN        = 16,
    parameter int ROM_AW          = 5
) (
    input logic                  CLK,
    input logic                  RST,
    oled_spi_sequencer_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, RES_LOW, RES_WAIT, ROM_FETCH, ROM_WAIT, SHIFT, GAP, READY
    } state_t;

    localparam int ResMax = (RES_LOW_CYCLES > RES_WAIT_CYCLES) ? RES_LOW_CYCLES : RES_WAIT_CYCLES;
    localparam int CntMax = (ResMax > CLK_DIV) ? ResMax : CLK_DIV;
    localparam int CW     = $clog2(CntMax + 1);
    localparam int LastIdx = (INIT_LEN > 0) ? INIT_LEN - 1 : 0;

    localparam logic [CW-1:0]     ResLowLast  = CW'(RES_LOW_CYCLES - 1);
    localparam logic [CW-1:0]     ResWaitLast = CW'(RES_WAIT_CYCLES - 1);
    localparam logic [CW-1:0]     DivLast     = CW'(CLK_DIV - 1);
    localparam logic [ROM_AW-1:0] LastAddr    = ROM_AW'(LastIdx);

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [ROM_AW-1:0] rom_addr_q, rom_addr_d;
    logic              resb_q, resb_d;
    logic              dcb_q, dcb_d;
    logic              csb_q, csb_d;
    logic              sck_q, sck_d;
    logic              sdout_q, sdout_d;
    logic              tx_ready_q, tx_ready_d;
    logic              busy_q, busy_d;
    logic              init_done_q, init_done_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rom_addr_q  <= '0;
            resb_q      <= 1'b1;
            dcb_q       <= 1'b0;
            csb_q       <= 1'b1;
            sck_q       <= 1'b1;
            sdout_q     <= 1'b1;
            tx_ready_q  <= 1'b0;
            busy_q      <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rom_addr_q  <= rom_addr_d;
            resb_q      <= resb_d;
            dcb_q       <= dcb_d;
            csb_q       <= csb_d;
            sck_q       <= sck_d;
            sdout_q     <= sdout_d;
            tx_ready_q  <= tx_ready_d;
            busy_q      <= busy_d;
            init_done_q <= init_done_d;
        end
    end

    // init_done doubles as the phase flag: low while streaming the ROM list, high for user bytes.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rom_addr_d  = rom_addr_q;
        resb_d      = resb_q;
        dcb_d       = dcb_q;
        csb_d       = csb_q;
        sck_d       = sck_q;
        sdout_d     = sdout_q;
        init_done_d = init_done_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d     = RES_LOW;
                    resb_d      = 1'b0;
                    init_done_d = 1'b0;
                    cnt_d       = '0;
                    rom_addr_d  = '0;
                end
            end
            READY: begin
                if (bus.start) begin
                    state_d     = RES_LOW;
                    resb_d      = 1'b0;
                    init_done_d = 1'b0;
                    cnt_d       = '0;
                    rom_addr_d  = '0;
                end else if (bus.tx_valid && tx_ready_q) begin
                    shift_d = bus.tx_data;
                    dcb_d   = bus.tx_dc;
                    state_d = SHIFT;
                end
            end
            RES_LOW: begin
                if (cnt_q == ResLowLast) begin
                    resb_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = RES_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RES_WAIT: begin
                if (cnt_q == ResWaitLast) begin
                    cnt_d = '0;
                    if (INIT_LEN == 0) begin
                        init_done_d = 1'b1;
                        state_d     = READY;
                    end else begin
                        rom_addr_d = '0;
                        state_d    = ROM_FETCH;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ROM_FETCH: begin
                state_d = ROM_WAIT;
            end
            ROM_WAIT: begin
                shift_d = bus.rom_data[7:0];
                dcb_d   = bus.rom_data[8];
                state_d = SHIFT;
            end
            SHIFT: begin
                // CSb still high marks the CS-assert cycle; it also lands the first falling SCK edge.
                if (csb_q) begin
                    csb_d     = 1'b0;
                    sck_d     = 1'b0;
                    sdout_d   = shift_q[7];
                    shift_d   = {shift_q[6:0], 1'b0};
                    cnt_d     = '0;
                    bit_cnt_d = '0;
                end else if (cnt_q != DivLast) begin
                    cnt_d = cnt_q + CW'(1);
                end else begin
                    cnt_d = '0;
                    if (!sck_q) begin
                        sck_d = 1'b1;
                    end else if (bit_cnt_q == 3'd7) begin
                        csb_d   = 1'b1;
                        sdout_d = 1'b1;
                        state_d = GAP;
                    end else begin
                        sck_d     = 1'b0;
                        sdout_d   = shift_q[7];
                        shift_d   = {shift_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
            end
            GAP: begin
                if (cnt_q == DivLast) begin
                    cnt_d = '0;
                    if (init_done_q) begin
                        state_d = READY;
                    end else if (rom_addr_q != LastAddr) begin
                        rom_addr_d = rom_addr_q + ROM_AW'(1);
                        state_d    = ROM_FETCH;
                    end else begin
                        init_done_d = 1'b1;
                        state_d     = READY;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d     = (state_d != IDLE) && (state_d != READY);
        tx_ready_d = (state_d == READY);
    end

    assign bus.rom_addr   = rom_addr_q;
    assign bus.tx_ready   = tx_ready_q;
    assign bus.busy       = busy_q;
    assign bus.init_done  = init_done_q;
    assign bus.RESb       = resb_q;
    assign bus.DCb        = dcb_q;
    assign bus.OLED_CSb   = csb_q;
    assign bus.OLED_SCK   = sck_q;
    assign bus.OLED_SDOUT = sdout_q;
endmodule

// File: tb/tb_oled_spi_sequencer.sv
// Bench for oled_spi_sequencer: a pin-level SPI decoder feeds a queue that is compared against
// the byte stream the panel should see (init list, then accepted user bytes).
module tb_oled_spi_sequencer;
    localparam int DIV = 2;
    localparam int RL  = 10;
    localparam int RW  = 5;
    localparam int NINIT = 3;
    localparam int AW  = 5;
    localparam int RLB = 6;
    localparam int RWB = 4;

    logic CLK = 1'b0;
    logic RST;
    int   checks = 0;
    int   errors = 0;

    oled_spi_sequencer_if #(.ROM_AW(AW)) busA ();
    oled_spi_sequencer_if #(.ROM_AW(AW)) busB ();

    oled_spi_sequencer #(
        .CLK_DIV(DIV), .RES_LOW_CYCLES(RL), .RES_WAIT_CYCLES(RW), .INIT_LEN(NINIT), .ROM_AW(AW)
    ) dutA (.CLK(CLK), .RST(RST), .bus(busA));

    oled_spi_sequencer #(
        .CLK_DIV(DIV), .RES_LOW_CYCLES(RLB), .RES_WAIT_CYCLES(RWB), .INIT_LEN(0), .ROM_AW(AW)
    ) dutB (.CLK(CLK), .RST(RST), .bus(busB));

    always #5 CLK = ~CLK;

    logic [8:0] romTable [32];
    logic [8:0] initList [NINIT];

    always @(posedge CLK) busA.rom_data <= romTable[busA.rom_addr];

    // Pin monitor: samples at posedge, i.e. the value each register held over the cycle just ended.
    logic [8:0] wireQ [$];
    int         winQ [$];
    int         gapQ [$];
    logic       doneQ [$];
    logic [8:0] expQ [$];
    int  cyc = 0, toggles = 0, bothHigh = 0, csActB = 0;
    int  resbRun = 0, resbLowLen = 0, resbRiseCyc = 0, firstFall = -1;
    int  winLen = 0, highRun = 0, bits = 0;
    bit  haveWin = 0, readyInByte = 0;
    logic [7:0] shreg;
    logic curDc;
    logic prevCsb = 1, prevSck = 1, prevResb = 1, prevDcb = 0, prevSdo = 1;

    initial begin
        forever begin
            @(posedge CLK);
            cyc++;
            if (busA.RESb !== prevResb || busA.DCb !== prevDcb || busA.OLED_CSb !== prevCsb ||
                busA.OLED_SCK !== prevSck || busA.OLED_SDOUT !== prevSdo)
                toggles++;
            if (busA.tx_ready === 1'b1 && busA.busy === 1'b1) bothHigh++;
            if (busB.OLED_CSb !== 1'b1) csActB++;
            if (busA.RESb === 1'b0) begin
                resbRun++;
            end else if (prevResb === 1'b0) begin
                resbLowLen  = resbRun;
                resbRun     = 0;
                resbRiseCyc = cyc;
                firstFall   = -1;
            end
            if (busA.OLED_CSb === 1'b0) begin
                if (prevCsb === 1'b1) begin
                    if (haveWin) gapQ.push_back(highRun);
                    if (firstFall < 0) firstFall = cyc - resbRiseCyc;
                    bits   = 0;
                    shreg  = '0;
                    winLen = 0;
                    curDc  = busA.DCb;
                end
                winLen++;
                if (busA.OLED_SCK === 1'b1 && prevSck === 1'b0) begin
                    shreg = {shreg[6:0], busA.OLED_SDOUT};
                    bits++;
                end
                if (busA.tx_ready === 1'b1) readyInByte = 1;
            end else begin
                if (prevCsb === 1'b0) begin
                    if (bits == 8) begin
                        wireQ.push_back({curDc, shreg});
                        winQ.push_back(winLen);
                        doneQ.push_back(busA.init_done);
                    end
                    haveWin = 1;
                    highRun = 0;
                end
                highRun++;
            end
            prevCsb  = busA.OLED_CSb;
            prevSck  = busA.OLED_SCK;
            prevResb = busA.RESb;
            prevDcb  = busA.DCb;
            prevSdo  = busA.OLED_SDOUT;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic clearMonitor();
        wireQ.delete();
        winQ.delete();
        gapQ.delete();
        doneQ.delete();
        expQ.delete();
        haveWin     = 0;
        readyInByte = 0;
    endtask

    task automatic applyStimulus(input bit sendStart, input bit sendByte, input logic [8:0] b);
        busA.start    = sendStart;
        busA.tx_valid = sendByte;
        busA.tx_dc    = b[8];
        busA.tx_data  = b[7:0];
        @(negedge CLK);
        busA.start    = 1'b0;
        busA.tx_valid = 1'b0;
    endtask

    task automatic waitReady(input string tag, output int n);
        n = 0;
        while (busA.tx_ready !== 1'b1 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        checkOutput({tag, "_reach_ready"}, 32'(busA.tx_ready), 32'd1);
    endtask

    task automatic compareWire(input string tag);
        checkOutput({tag, "_count"}, wireQ.size(), expQ.size());
        for (int i = 0; i < expQ.size(); i++)
            checkOutput($sformatf("%s_byte%0d", tag, i),
                        (i < wireQ.size()) ? 32'(wireQ[i]) : 32'hDEAD, 32'(expQ[i]));
    endtask

    task automatic checkTiming(input string tag, input int gapExp);
        for (int i = 0; i < winQ.size(); i++)
            checkOutput($sformatf("%s_window%0d", tag, i), winQ[i], 16 * DIV);
        for (int i = 0; i < gapQ.size(); i++)
            checkOutput($sformatf("%s_gap%0d", tag, i), gapQ[i], gapExp);
    endtask

    initial begin
        int n, sent, t0;
        bit accept;
        logic [8:0] b;

        for (int i = 0; i < 32; i++) romTable[i] = 9'h1FF;
        romTable[0] = 9'h0AE;
        romTable[1] = 9'h1A5;
        romTable[2] = 9'h08D;
        for (int i = 0; i < NINIT; i++) initList[i] = romTable[i];

        RST = 1'b1;
        busA.start = 0; busA.tx_valid = 0; busA.tx_data = 0; busA.tx_dc = 0;
        busB.start = 0; busB.tx_valid = 0; busB.tx_data = 0; busB.tx_dc = 0; busB.rom_data = '0;

        // Reset state
        repeat (3) @(negedge CLK);
        checkOutput("rst_RESb", 32'(busA.RESb), 1);
        checkOutput("rst_DCb", 32'(busA.DCb), 0);
        checkOutput("rst_CSb", 32'(busA.OLED_CSb), 1);
        checkOutput("rst_SCK", 32'(busA.OLED_SCK), 1);
        checkOutput("rst_SDOUT", 32'(busA.OLED_SDOUT), 1);
        checkOutput("rst_tx_ready", 32'(busA.tx_ready), 0);
        checkOutput("rst_busy", 32'(busA.busy), 0);
        checkOutput("rst_init_done", 32'(busA.init_done), 0);
        checkOutput("rst_rom_addr", 32'(busA.rom_addr), 0);
        checkOutput("rstB_init_done", 32'(busB.init_done), 0);
        RST = 1'b0;

        // Idle: tx_valid ignored, pins quiet
        t0 = toggles;
        for (int i = 0; i < 100; i++) begin
            busA.tx_valid = 1'($urandom_range(0, 1));
            busA.tx_data  = 8'($urandom);
            @(negedge CLK);
        end
        busA.tx_valid = 0;
        checkOutput("idle_toggles", toggles - t0, 0);
        checkOutput("idle_tx_ready", 32'(busA.tx_ready), 0);
        checkOutput("idle_busy", 32'(busA.busy), 0);

        // Power-up and init stream
        clearMonitor();
        applyStimulus(1'b1, 1'b0, 9'h0);
        checkOutput("pu_RESb_low", 32'(busA.RESb), 0);
        checkOutput("pu_busy", 32'(busA.busy), 1);
        waitReady("init", n);
        checkOutput("pu_resb_low_len", resbLowLen, RL);
        // RES_WAIT, then ROM_FETCH, ROM_WAIT and the CS-assert cycle
        checkOutput("pu_first_cs_fall", firstFall, RW + 3);
        for (int i = 0; i < NINIT; i++) expQ.push_back(initList[i]);
        compareWire("init");
        checkTiming("init", DIV + 3);
        checkOutput("init_windows", winQ.size(), NINIT);
        for (int i = 0; i < doneQ.size(); i++)
            checkOutput($sformatf("init_done_during%0d", i), 32'(doneQ[i]), 0);
        checkOutput("init_done_after", 32'(busA.init_done), 1);
        checkOutput("init_busy_after", 32'(busA.busy), 0);

        // Single user byte
        clearMonitor();
        applyStimulus(1'b0, 1'b1, 9'h13C);
        checkOutput("user_ready_drop", 32'(busA.tx_ready), 0);
        checkOutput("user_busy", 32'(busA.busy), 1);
        checkOutput("user_DCb", 32'(busA.DCb), 1);
        checkOutput("user_CSb_still_high", 32'(busA.OLED_CSb), 1);
        @(negedge CLK);
        checkOutput("user_CSb_low", 32'(busA.OLED_CSb), 0);
        waitReady("user", n);
        expQ.push_back(9'h13C);
        compareWire("user");
        checkTiming("user", 0);
        checkOutput("user_ready_in_byte", 32'(readyInByte), 0);

        // Back-to-back random bytes with tx_valid held
        clearMonitor();
        sent = 0;
        b = 9'($urandom);
        busA.tx_dc = b[8]; busA.tx_data = b[7:0]; busA.tx_valid = 1'b1;
        for (int c = 0; c < 2000 && sent < 4; c++) begin
            accept = busA.tx_ready;
            @(negedge CLK);
            if (accept) begin
                expQ.push_back(b);
                sent++;
                if (sent < 4) begin
                    b = 9'($urandom);
                    busA.tx_dc = b[8]; busA.tx_data = b[7:0];
                end else begin
                    busA.tx_valid = 1'b0;
                end
            end
        end
        busA.tx_valid = 1'b0;
        checkOutput("b2b_accepted", sent, 4);
        waitReady("b2b", n);
        compareWire("b2b");
        // GAP, the READY transfer cycle, then the CS-assert cycle
        checkTiming("b2b", DIV + 2);
        checkOutput("b2b_readyInByte", 32'(readyInByte), 0);
        checkOutput("b2b_ready_and_busy", bothHigh, 0);

        // start and tx_valid together: start wins
        clearMonitor();
        applyStimulus(1'b1, 1'b1, 9'($urandom));
        checkOutput("col_init_done", 32'(busA.init_done), 0);
        checkOutput("col_RESb", 32'(busA.RESb), 0);
        checkOutput("col_tx_ready", 32'(busA.tx_ready), 0);
        waitReady("col", n);
        for (int i = 0; i < NINIT; i++) expQ.push_back(initList[i]);
        compareWire("col");
        checkOutput("col_init_done_after", 32'(busA.init_done), 1);

        // Reset mid-byte
        clearMonitor();
        applyStimulus(1'b0, 1'b1, 9'($urandom));
        repeat (9) @(negedge CLK);
        checkOutput("mid_CSb_active", 32'(busA.OLED_CSb), 0);
        RST = 1'b1;
        @(negedge CLK);
        checkOutput("mid_CSb", 32'(busA.OLED_CSb), 1);
        checkOutput("mid_SCK", 32'(busA.OLED_SCK), 1);
        checkOutput("mid_SDOUT", 32'(busA.OLED_SDOUT), 1);
        checkOutput("mid_busy", 32'(busA.busy), 0);
        checkOutput("mid_tx_ready", 32'(busA.tx_ready), 0);
        checkOutput("mid_init_done", 32'(busA.init_done), 0);
        checkOutput("mid_DCb", 32'(busA.DCb), 0);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("mid_no_partial", wireQ.size(), 0);
        clearMonitor();
        applyStimulus(1'b1, 1'b0, 9'h0);
        waitReady("reinit", n);
        for (int i = 0; i < NINIT; i++) expQ.push_back(initList[i]);
        compareWire("reinit");
        checkTiming("reinit", DIV + 3);

        // Empty init list
        t0 = csActB;
        busB.start = 1'b1;
        @(negedge CLK);
        busB.start = 1'b0;
        checkOutput("empty_busy", 32'(busB.busy), 1);
        n = 0;
        while (busB.tx_ready !== 1'b1 && n < 5000) begin
            @(negedge CLK);
            n++;
        end
        checkOutput("empty_latency", n, RLB + RWB);
        checkOutput("empty_init_done", 32'(busB.init_done), 1);
        checkOutput("empty_busy_after", 32'(busB.busy), 0);
        checkOutput("empty_cs_activity", csActB - t0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
